// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit: tracks destination tags from EX to the
// last tracked stage, picks the youngest ready producer per EX operand and stalls ID on load-use.
module fwd_hazard_unit #(
    parameter  int REG_W      = 5,
    parameter  int N_SRC      = 2,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_STAGE = 2,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [N_SRC*REG_W-1:0] id_src,
    input  logic [REG_W-1:0]       id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_is_load,
    input  logic                   ext_stall,
    input  logic                   flush,
    output logic                   stall,
    output logic                   ex_valid,
    output logic [N_SRC*SEL_W-1:0] ex_sel,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic             pipe_v  [DEPTH];
    logic [REG_W-1:0] pipe_rd [DEPTH];
    logic             pipe_we [DEPTH];
    logic             pipe_ld [DEPTH];
    logic [REG_W-1:0] ex_src  [N_SRC];
    logic             hz_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    // A load younger than LOAD_STAGE-1 cannot feed an ID consumer by the time it reaches EX.
    always_comb begin
        hz_stall = 1'b0;
        if (id_valid && !flush) begin
            for (int k = 0; k < LOAD_STAGE - 1; k++) begin
                for (int j = 0; j < N_SRC; j++) begin
                    if (pipe_v[k] && pipe_we[k] && pipe_ld[k] && (pipe_rd[k] != '0) &&
                        (pipe_rd[k] == id_src[j*REG_W +: REG_W]))
                        hz_stall = 1'b1;
                end
            end
        end
    end

    // Scanning oldest to youngest lets the youngest qualifying producer overwrite.
    always_comb begin
        ex_sel = '0;
        for (int j = 0; j < N_SRC; j++) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (pipe_v[0] && pipe_v[k] && pipe_we[k] && (pipe_rd[k] != '0) &&
                    (pipe_rd[k] == ex_src[j]) && (!pipe_ld[k] || (k >= LOAD_STAGE)))
                    ex_sel[j*SEL_W +: SEL_W] = SEL_W'(k);
            end
        end
    end

    assign ex_valid = pipe_v[0];
    assign stall    = hz_stall | ext_stall;

    // ID -> pipe[0] -> ... -> pipe[DEPTH-1] : control
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) pipe_v[k] <= 1'b0;
            stall_cnt <= '0;
        end else if (!ext_stall) begin
            pipe_v[0] <= id_valid && !hz_stall && !flush;
            for (int k = 1; k < DEPTH; k++) pipe_v[k] <= pipe_v[k-1];
            if (hz_stall) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // ID -> pipe[0] -> ... -> pipe[DEPTH-1] : tags, qualified by pipe_v
    always_ff @(posedge clk) begin
        if (!ext_stall) begin
            pipe_rd[0] <= id_rd;
            pipe_we[0] <= id_reg_write;
            pipe_ld[0] <= id_is_load;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_rd[k] <= pipe_rd[k-1];
                pipe_we[k] <= pipe_we[k-1];
                pipe_ld[k] <= pipe_ld[k-1];
            end
            for (int j = 0; j < N_SRC; j++) ex_src[j] <= id_src[j*REG_W +: REG_W];
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three configurations driven with shared ID traffic, each
// compared every cycle against an in-flight instruction model plus directed scenario checks.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, id_reg_write, id_is_load, ext_stall, flush;
    logic [14:0] id_src3;
    logic [4:0]  id_rd;
    logic        stall0, stall1, stall2, ev0, ev1, ev2;
    logic [3:0]  sel0, sel2;
    logic [5:0]  sel1;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    fwd_hazard_unit u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src3[9:0]), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ext_stall(ext_stall),
        .flush(flush), .stall(stall0), .ex_valid(ev0), .ex_sel(sel0), .stall_cnt(cnt0));

    fwd_hazard_unit #(.N_SRC(3), .DEPTH(4), .LOAD_STAGE(3)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src3), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ext_stall(ext_stall),
        .flush(flush), .stall(stall1), .ex_valid(ev1), .ex_sel(sel1), .stall_cnt(cnt1));

    fwd_hazard_unit #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src3[9:0]), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ext_stall(ext_stall),
        .flush(flush), .stall(stall2), .ex_valid(ev2), .ex_sel(sel2), .stall_cnt(cnt2));

    int vectors = 0;
    int miscompares = 0;

    // Reference: per configuration, the instruction occupying each age slot (0 = EX).
    int          P_D [3] = '{3, 4, 3};
    int          P_L [3] = '{2, 3, 2};
    int          P_N [3] = '{2, 3, 2};
    int unsigned P_MAX [3] = '{65535, 65535, 3};
    logic        mv  [3][4];
    logic [4:0]  mrd [3][4];
    logic        mwe [3][4];
    logic        mld [3][4];
    logic [4:0]  msrc [3][3];
    int unsigned mcnt [3];
    bit          m_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] src_of(input int j);
        return id_src3[j*5 +: 5];
    endfunction

    // A load at age k reaches age k+1 when the ID consumer enters EX; its data is usable only from age L.
    function automatic logic m_hz(input int i);
        if (!id_valid || flush) return 1'b0;
        for (int k = 0; k < P_D[i]; k++)
            for (int j = 0; j < P_N[i]; j++)
                if (mv[i][k] && mwe[i][k] && mld[i][k] && mrd[i][k] != 5'd0 &&
                    mrd[i][k] == src_of(j) && (k + 1 < P_L[i]))
                    return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_sel(input int i, input int j);
        if (!mv[i][0]) return 0;
        for (int k = 1; k < P_D[i]; k++)
            if (mv[i][k] && mwe[i][k] && mrd[i][k] != 5'd0 && mrd[i][k] == msrc[i][j] &&
                (!mld[i][k] || k >= P_L[i]))
                return k;
        return 0;
    endfunction

    task automatic m_step(input int i, input logic hz);
        if (rst) begin
            for (int k = 0; k < 4; k++) mv[i][k] = 1'b0;
            mcnt[i] = 0;
        end else if (!ext_stall) begin
            for (int k = P_D[i] - 1; k >= 1; k--) begin
                mv[i][k]  = mv[i][k-1];
                mrd[i][k] = mrd[i][k-1];
                mwe[i][k] = mwe[i][k-1];
                mld[i][k] = mld[i][k-1];
            end
            mv[i][0]  = id_valid && !hz && !flush;
            mrd[i][0] = id_rd;
            mwe[i][0] = id_reg_write;
            mld[i][0] = id_is_load;
            for (int j = 0; j < 3; j++) msrc[i][j] = src_of(j);
            if (hz && mcnt[i] < P_MAX[i]) mcnt[i]++;
        end
    endtask

    task automatic compare_inst(input int i, input logic st, input logic ev,
                                input logic [5:0] sel, input logic [15:0] cnt, input logic hz);
        chk($sformatf("u%0d_stall", i), 32'(st), 32'(hz | ext_stall));
        chk($sformatf("u%0d_ex_valid", i), 32'(ev), 32'(mv[i][0]));
        for (int j = 0; j < P_N[i]; j++)
            chk($sformatf("u%0d_ex_sel%0d", i, j), 32'(sel[j*2 +: 2]), 32'(m_sel(i, j)));
        chk($sformatf("u%0d_stall_cnt", i), 32'(cnt), 32'(mcnt[i]));
    endtask

    task automatic cycle();
        logic hz [3];
        #1;
        for (int i = 0; i < 3; i++) hz[i] = m_hz(i);
        if (m_ok) begin
            compare_inst(0, stall0, ev0, {2'b00, sel0}, cnt0, hz[0]);
            compare_inst(1, stall1, ev1, sel1, cnt1, hz[1]);
            compare_inst(2, stall2, ev2, {2'b00, sel2}, {14'd0, cnt2}, hz[2]);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) m_step(i, hz[i]);
        if (rst) m_ok = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                          input logic [4:0] s0, input logic [4:0] s1);
        id_valid = v; id_rd = rd; id_reg_write = we; id_is_load = ld;
        id_src3 = {5'd0, s1, s0};
        rst = 1'b0; ext_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] s0, input logic [4:0] s1);
        set_id(v, rd, we, ld, s0, s1);
        cycle();
    endtask

    task automatic nops(input int n);
        for (int c = 0; c < n; c++) issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    task automatic randomize_inputs();
        id_valid     = ($urandom_range(3) != 0);
        id_rd        = 5'($urandom_range(7));
        id_reg_write = 1'($urandom);
        id_is_load   = 1'($urandom);
        id_src3      = {5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7))};
        ext_stall    = ($urandom_range(7) == 0);
        flush        = ($urandom_range(7) == 0);
    endtask

    initial begin
        int unsigned cnt_before;
        rst = 1'b1;
        randomize_inputs();
        @(negedge clk);
        cycle();
        randomize_inputs();
        #1;
        chk("rst_ex_valid", 32'(ev0), 32'd0);
        chk("rst_ex_sel", 32'(sel0), 32'd0);
        chk("rst_stall_cnt", 32'(cnt0), 32'd0);
        chk("rst_stall", 32'(stall0), 32'(ext_stall));
        chk("rst_ex_sel_u1", 32'(sel1), 32'd0);
        cycle();

        // ALU chain, back-to-back then one nop apart
        nops(4);
        issue(1, 5'd3, 1, 0, 5'd1, 5'd2);
        issue(1, 5'd4, 1, 0, 5'd3, 5'd3);
        #1;
        chk("alu_b2b_sel_u0", 32'(sel0), 32'd5);
        chk("alu_b2b_sel_u1", 32'(sel1), 32'd5);
        chk("alu_b2b_stall", 32'(stall0), 32'd0);
        issue(1, 5'd3, 1, 0, 5'd1, 5'd2);
        issue(0, 5'd0, 0, 0, 5'd0, 5'd0);
        issue(1, 5'd4, 1, 0, 5'd3, 5'd3);
        chk("alu_gap_sel_u0", 32'(sel0), 32'd10);

        // double producer of r5, then r0 destination
        nops(3);
        issue(1, 5'd5, 1, 0, 5'd0, 5'd0);
        issue(1, 5'd5, 1, 0, 5'd0, 5'd0);
        issue(1, 5'd9, 1, 0, 5'd5, 5'd0);
        chk("dbl_prod_sel", 32'(sel0), 32'd1);
        nops(3);
        issue(1, 5'd0, 1, 0, 5'd1, 5'd1);
        issue(1, 5'd6, 1, 0, 5'd0, 5'd0);
        chk("r0_dest_sel", 32'(sel0), 32'd0);
        chk("r0_dest_valid", 32'(ev0), 32'd1);

        // load-use: lw r7 ; add r8,r7,r1
        nops(4);
        issue(1, 5'd7, 1, 1, 5'd1, 5'd2);
        set_id(1, 5'd8, 1, 0, 5'd7, 5'd1);
        #1;
        chk("lu_stall_u0", 32'(stall0), 32'd1);
        chk("lu_stall_u1", 32'(stall1), 32'd1);
        cycle();
        #1;
        chk("lu_release_u0", 32'(stall0), 32'd0);
        chk("lu_bubble_u0", 32'(ev0), 32'd0);
        chk("lu_hold_u1", 32'(stall1), 32'd1);
        cycle();
        chk("lu_fwd_sel_u0", 32'(sel0), 32'd2);
        chk("lu_cnt_u0", 32'(cnt0), 32'd1);
        #1;
        chk("lu_release_u1", 32'(stall1), 32'd0);
        cycle();
        chk("lu_fwd_sel0_u1", 32'(sel1[1:0]), 32'd3);
        chk("lu_fwd_sel1_u1", 32'(sel1[3:2]), 32'd0);
        chk("lu_cnt_u1", 32'(cnt1), 32'd2);

        // flush with load-use pending
        nops(4);
        issue(1, 5'd7, 1, 1, 5'd0, 5'd0);
        set_id(1, 5'd8, 1, 0, 5'd7, 5'd1);
        flush = 1'b1;
        #1;
        chk("flush_stall_u0", 32'(stall0), 32'd0);
        chk("flush_stall_u1", 32'(stall1), 32'd0);
        cycle();
        chk("flush_bubble", 32'(ev0), 32'd0);

        // freeze mid-chain with a load-use pending at ID
        nops(4);
        issue(1, 5'd3, 1, 0, 5'd1, 5'd2);
        issue(1, 5'd9, 1, 1, 5'd3, 5'd0);
        cnt_before = mcnt[0];
        set_id(1, 5'd10, 1, 0, 5'd9, 5'd9);
        ext_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("frz_stall", 32'(stall0), 32'd1);
            cycle();
            chk("frz_sel", 32'(sel0), 32'd1);
            chk("frz_valid", 32'(ev0), 32'd1);
            chk("frz_cnt", 32'(cnt0), 32'(cnt_before));
        end
        ext_stall = 1'b0;
        cycle();

        // saturation of the 2-bit counter
        for (int r = 0; r < 5; r++) begin
            nops(2);
            issue(1, 5'd7, 1, 1, 5'd0, 5'd0);
            issue(1, 5'd8, 1, 0, 5'd7, 5'd7);
            issue(1, 5'd8, 1, 0, 5'd7, 5'd7);
        end
        chk("sat_cnt_u2", 32'(cnt2), 32'd3);

        // random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            rst = ($urandom_range(63) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
